// File: rtl/plant_emulator.sv
// rtl/plant_emulator.sv - first-order-lag plant with transport delay for closing a PID loop
//
// Purpose:
//   Discrete-time plant driven by a controller output. Each prescaled sample
//   tick shifts control_in into a DELAY-deep delay line and feeds the oldest
//   entry into a first-order lag: acc += u - (acc >> TAU_SHIFT). The plant
//   output is acc >> TAU_SHIFT.
//
// Optional feature macro:
//   PLANT_NOISE_EN - adds +/-1 LSB pseudo-random noise from an 8-bit LFSR to
//                    feedback_out (clamped to 0..2^WIDTH-1). Settle detection
//                    always uses the noise-free value.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   run enable; all state freezes while low
//   control_in   in   controller output (unsigned, WIDTH)
//   feedback_out out  registered plant output (unsigned, WIDTH)
//   sample_tick  out  one-cycle pulse on each plant update
//   valid        out  delay line primed (state RUN)
//   settled      out  output equalled delayed input for 8 consecutive ticks

module plant_emulator #(
  parameter int WIDTH     = 8,
  parameter int DELAY     = 4,
  parameter int PRESCALE  = 16,
  parameter int TAU_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] control_in,
  output logic [WIDTH-1:0] feedback_out,
  output logic             sample_tick,
  output logic             valid,
  output logic             settled
);

  localparam int AW = WIDTH + TAU_SHIFT;
  localparam int PW = $clog2(PRESCALE);
  localparam int FW = $clog2(DELAY + 1);
  localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FLAST = FW'(DELAY - 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic             tick_q;
  logic [WIDTH-1:0] d_q [DELAY];

  logic             tick;
  logic [WIDTH-1:0] u;
  logic signed [AW:0] diff;
  logic [WIDTH-1:0] fb_clean;

`ifdef PLANT_NOISE_EN
  logic [7:0]           lfsr_q, lfsr_d;
  logic signed [WIDTH+1:0] noise;
  logic signed [WIDTH+1:0] fb_sum;
`endif

  // Prescaler and plant datapath.
  always_comb begin
    tick   = ena && (pcnt_q == PTERM);
    pcnt_d = pcnt_q;
    if (ena) pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    // During FILL the delay line still holds reset zeros; gating keeps u
    // defined as zero regardless.
    u = (state_q == RUN) ? d_q[DELAY-1] : '0;

    // Signed difference one bit wider than acc; the result is provably
    // non-negative, so the sign-bit guard never fires in practice.
    diff = $signed({1'b0, acc_q})
         + $signed({{(AW+1-WIDTH){1'b0}}, u})
         - $signed({1'b0, acc_q >> TAU_SHIFT});
    acc_d    = tick ? (diff[AW] ? '0 : diff[AW-1:0]) : acc_q;
    fb_clean = acc_d[AW-1:TAU_SHIFT];

    // Settle counter compares the new noise-free output with this tick's u.
    scnt_d = scnt_q;
    if (tick) begin
      if (fb_clean == u) scnt_d = (scnt_q == 4'd8) ? 4'd8 : scnt_q + 4'd1;
      else               scnt_d = 4'd0;
    end

`ifdef PLANT_NOISE_EN
    lfsr_d = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    noise  = '0;
    if (lfsr_d[1:0] == 2'b00)      noise = '1;  // -1
    else if (lfsr_d[1:0] == 2'b11) noise = (WIDTH+2)'(1);
    fb_sum = $signed({2'b00, fb_clean}) + noise;
    fb_d   = fb_q;
    if (tick) begin
      if (fb_sum[WIDTH+1])  fb_d = '0;
      else if (fb_sum[WIDTH]) fb_d = '1;
      else                  fb_d = fb_sum[WIDTH-1:0];
    end
`else
    fb_d = tick ? fb_clean : fb_q;
`endif
  end

  // FILL/RUN state machine: next state.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (tick && state_q == FILL) begin
      fcnt_d = fcnt_q + FW'(1);
      if (fcnt_q == FLAST) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      acc_q   <= '0;
      fb_q    <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < DELAY; i++) d_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
      acc_q   <= acc_d;
      fb_q    <= fb_d;
      tick_q  <= tick;
      if (tick) begin
        d_q[0] <= control_in;
        for (int i = 1; i < DELAY; i++) d_q[i] <= d_q[i-1];
      end
    end
  end

`ifdef PLANT_NOISE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign feedback_out = fb_q;
  assign sample_tick  = tick_q;
  assign valid        = (state_q == RUN);
  assign settled      = (state_q == RUN) && (scnt_q == 4'd8);

endmodule

// File: doc/plant_emulator.md
# plant_emulator

Discrete-time plant model that closes the loop around `tt_um_pid_controller`. It consumes the controller's 8-bit control signal and produces the 8-bit feedback value the controller reads. The plant is a first-order lag with a programmable transport delay, updated on a prescaled sample tick. It is used in loop-level benches, and optionally on-chip, so the PID can be exercised without an external plant.

## Interface
Parameters:
- `WIDTH`, 8: data width of control and feedback.
- `DELAY`, 4: transport delay in sample ticks (legal range 1..16).
- `PRESCALE`, 16: clock cycles per sample tick (legal range 2..256).
- `TAU_SHIFT`, 3: lag constant as a right shift (legal range 1..6).

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `ena`, input, 1: run enable. While low, all state freezes.
- `control_in`, input, WIDTH: controller output, unsigned.
- `feedback_out`, output, WIDTH: plant output to the controller feedback input, unsigned, registered.
- `sample_tick`, output, 1: one-cycle pulse on each plant update.
- `valid`, output, 1: delay line primed (state RUN).
- `settled`, output, 1: output has equalled the delayed input for 8 consecutive ticks.

## Operation
- **Prescaler.** `pcnt` counts 0..PRESCALE-1 while `ena`=1 and holds while `ena`=0. The tick fires in the cycle where `pcnt`==PRESCALE-1 and `ena`=1. `pcnt` then wraps to 0.
- **Delay line.** Entries `d[0..DELAY-1]`. On each tick:
  - `d[0]` <= `control_in`.
  - `d[i]` <= `d[i-1]`.
  - The old `d[DELAY-1]` is the plant input `u` for that tick.
- **Lag.** Unsigned accumulator `acc` is WIDTH+TAU_SHIFT bits wide.
  - On tick: `acc` <= `acc` + `u` - (`acc` >> TAU_SHIFT).
  - Compute the difference in WIDTH+TAU_SHIFT+1 bits, signed.
  - No overflow is possible: `acc` stays at or below (255<<T)+2^T-1.
  - `feedback_out` = `acc` >> TAU_SHIFT. At steady state it equals `u` exactly.
- **State machine.** Two states, FILL and RUN.
  - Reset enters FILL. `fcnt` counts ticks.
  - After DELAY ticks in FILL, the machine moves to RUN and `valid`=1.
  - RUN holds until reset.
  - `acc` updates in both states. In FILL the plant input `u` is the reset value 0.
- **Settle detection.**
  - `scnt` (4 bits) saturates at 8. It increments on a tick where the new `feedback_out` equals `u`.
  - Any tick where they differ clears `scnt` to 0.
  - `settled` = RUN && `scnt`==8.
- **Simultaneous events.** A change on `control_in` in the tick cycle is captured in that same tick. `ena` falling in the tick cycle suppresses that tick.

## Timing
- **Reset values.** `feedback_out`=0, `sample_tick`=0, `valid`=0, `settled`=0. Internally `pcnt`, `acc`, `d[*]`, `fcnt` and `scnt` are 0, and the state is FILL.
- **Reset mid-operation.** Asynchronous clear to the values above. The first tick comes PRESCALE cycles after `rst_n` deasserts with `ena`=1.
- **Tick outputs.** `sample_tick` is registered and high in the cycle after the prescaler terminal count. `acc` and `feedback_out` update on the same edge that raises `sample_tick`.
- **Transport latency.** A value sampled at tick k first affects `feedback_out` at tick k+DELAY.
- **State flags.** `valid` rises on the edge of the DELAY-th tick after reset. `settled` rises on the edge of the qualifying tick.
- **Enable.** With `ena`=0 there are no ticks, every register holds, and outputs stay stable.

## Configuration
- **`PLANT_NOISE_EN` defined:** an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5, never zero) advances on each tick.
  - Noise n depends on `lfsr[1:0]`: 00 gives -1, 11 gives +1, otherwise 0.
  - `feedback_out` = clamp(`acc`>>T + n, 0, 255).
  - Settle comparison uses the un-noised value.
- **`PLANT_NOISE_EN` undefined:** there is no LFSR, and `feedback_out` = `acc`>>T exactly.

## Test plan
All scenarios use the default parameters and have `PLANT_NOISE_EN` undefined unless stated.
1. **Reset and fill.** Reset, `ena`=1, `control_in`=0 → first `sample_tick` 16 cycles after release. `valid`=0 through tick 3 and 1 from tick 4. `feedback_out`=0 throughout.
2. **Step response.** Step `control_in` 0→200 just before tick k → `feedback_out` stays 0 through tick k+3.
   - Tick k+4 gives 25, tick k+5 gives 46 (`acc`=375).
   - Output is monotonic, reaches exactly 200, then `settled`=1 after 8 more ticks.
3. **Enable freeze.** Drop `ena` for 50 cycles mid-transient → no `sample_tick`, and `feedback_out` and `pcnt` are unchanged. Resuming continues the same sequence.
4. **Reset mid-transient.** Assert `rst_n`=0 while `feedback_out`=120 → immediately all outputs are 0 and the state is FILL, without waiting for a clock edge.
5. **Full-scale.** Hold `control_in`=255 → `feedback_out` converges to 255 with no wrap. Then step to 0 → output decays to exactly 0 and `settled` reasserts.
6. **Noise build.** With `PLANT_NOISE_EN`, hold `control_in`=0 after settling → `feedback_out` ∈ {0,1}, never 255. `settled` stays 1.
